fifo_drain: RTL and testbench



---
 rtl/fifo_drain_pkg.sv | 26 ++
 rtl/fifo_drain_wbuf.sv | 67 ++++++
 rtl/fifo_drain.sv | 167 ++++++++++++++++
 tb/tb_fifo_drain.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg
//   Shared types and constants for the FIFO drain stage.
//   - state_t    : serialiser FSM states (IDLE, SHIFT)
//   - byte_idx_t : 2-bit index of the byte currently presented
//   - WORD_BYTES, BYTE_W, WORD_W : word/byte geometry
//   - byte_sel() : little-endian byte extraction from a word
package fifo_drain_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef logic [1:0] byte_idx_t;

    // Byte 0 lives in bits [7:0].
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                   input byte_idx_t         idx);
        return word[BYTE_W*idx +: BYTE_W];
    endfunction

endpackage

// File: rtl/fifo_drain_wbuf.sv
// fifo_drain_wbuf
//   Small circular word buffer between the FIFO read port and the serialiser.
//   Ports:
//     clock, reset_n   : clock, asynchronous active-low reset (pointers/occupancy)
//     push, push_data  : write one word (ignored when full unless popping too)
//     pop              : remove the head word (ignored when empty)
//     head             : word at the read pointer, valid when empty is low
//     occ              : number of stored words
//     empty            : occ == 0
module fifo_drain_wbuf
    import fifo_drain_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic [OCC_W-1:0]  occ,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (occ == '0);
    assign full    = (occ == OCC_W'(DEPTH));
    // A push into a full buffer is still safe when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries data only; no reset needed.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain
//   Read stage for the byte-packing FIFO: issues credit-limited reads, buffers
//   returned words and serialises them little-endian over valid/ready.
//   Build option: FIFO_DRAIN_CKSUM_EN adds a running XOR checksum of emitted bytes.
//   Ports:
//     clock, reset_n          : clock, asynchronous active-low reset
//     cksum, cksum_clr        : checksum value / synchronous clear (option only)
//     fifo_empty              : FIFO empty flag
//     fifo_r_en               : FIFO read request (combinational, forced low in reset)
//     fifo_valid_out          : FIFO read data valid, one cycle after fifo_r_en
//     fifo_data_out           : FIFO read data, byte 0 in [7:0]
//     byte_valid/data/eow     : output byte stream, eow marks byte 3 of a word
//     byte_ready              : downstream accept
//     word_count              : words fully emitted since reset (wraps)
//     proto_err               : sticky, data valid seen with no read in flight
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
`ifdef FIFO_DRAIN_CKSUM_EN
    output logic [BYTE_W-1:0]    cksum,
    input  logic                 cksum_clr,
`endif
    input  logic                 fifo_empty,
    output logic                 fifo_r_en,
    input  logic                 fifo_valid_out,
    input  logic [WORD_W-1:0]    fifo_data_out,
    output logic                 byte_valid,
    output logic [BYTE_W-1:0]    byte_data,
    output logic                 byte_eow,
    input  logic                 byte_ready,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic                 proto_err
);

    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam int SUM_W = OCC_W + 1;

    state_t            state;
    byte_idx_t         idx;
    logic [WORD_W-1:0] sreg;
    logic              inflight;

    logic [WORD_W-1:0] buf_head;
    logic [OCC_W-1:0]  buf_occ;
    logic              buf_empty;
    logic              buf_push;
    logic              buf_pop;

    logic [SUM_W-1:0]  pending;
    logic              capture;
    logic              bad_valid;
    logic              word_avail;
    logic [WORD_W-1:0] next_word;
    logic              accept;
    logic              last;
    logic              take;
    byte_idx_t         idx_inc;

    // Credit: buffered words plus the read still in flight must leave room.
    assign pending   = SUM_W'(buf_occ) + SUM_W'(inflight);
    assign fifo_r_en = reset_n && !fifo_empty && (pending < SUM_W'(BUF_DEPTH));

    assign capture   = fifo_valid_out && inflight;
    assign bad_valid = fifo_valid_out && !inflight;

    // A word returning this cycle counts as available so the first byte appears
    // two cycles after the read and back-to-back words need no bubble.
    assign word_avail = !buf_empty || capture;
    assign next_word  = buf_empty ? fifo_data_out : buf_head;

    assign accept  = byte_valid && byte_ready;
    assign last    = accept && (idx == byte_idx_t'(WORD_BYTES - 1));
    assign take    = word_avail && ((state == IDLE) || last);
    assign idx_inc = idx + byte_idx_t'(1);

    // Returned word bypasses the buffer when it is consumed immediately.
    assign buf_pop  = take && !buf_empty;
    assign buf_push = capture && !(take && buf_empty);

    fifo_drain_wbuf #(
        .DEPTH (BUF_DEPTH)
    ) u_wbuf (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (buf_push),
        .push_data (fifo_data_out),
        .pop       (buf_pop),
        .head      (buf_head),
        .occ       (buf_occ),
        .empty     (buf_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            inflight <= fifo_r_en;
            if (bad_valid) proto_err <= 1'b1;
        end
    end

    // Serialiser FSM with registered byte outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_eow   <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state      <= SHIFT;
                        idx        <= '0;
                        byte_valid <= 1'b1;
                        byte_data  <= byte_sel(next_word, '0);
                        byte_eow   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        word_count <= word_count + CNT_WIDTH'(1);
                        idx        <= '0;
                        byte_eow   <= 1'b0;
                        if (take) begin
                            byte_data <= byte_sel(next_word, '0);
                        end else begin
                            state      <= IDLE;
                            byte_valid <= 1'b0;
                        end
                    end else if (accept) begin
                        idx       <= idx_inc;
                        byte_data <= byte_sel(sreg, idx_inc);
                        byte_eow  <= (idx_inc == byte_idx_t'(WORD_BYTES - 1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (take) sreg <= next_word;
    end

`ifdef FIFO_DRAIN_CKSUM_EN
    // Clear wins over a same-cycle update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cksum <= '0;
        end else if (cksum_clr) begin
            cksum <= '0;
        end else if (accept) begin
            cksum <= cksum ^ byte_data;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
module tb_fifo_drain;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_WIDTH = 16;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 fifo_empty;
    logic                 fifo_r_en;
    logic                 fifo_valid_out;
    logic [31:0]          fifo_data_out;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 byte_eow;
    logic                 byte_ready;
    logic [CNT_WIDTH-1:0] word_count;
    logic                 proto_err;
`ifdef FIFO_DRAIN_CKSUM_EN
    logic [7:0]           cksum;
    logic                 cksum_clr;
`endif

    // FIFO model state
    logic        model_rd;
    logic        model_vld;
    logic [31:0] model_data;
    logic        err_pulse;
    logic [31:0] fifo_q[$];
    logic [8:0]  exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    assign fifo_valid_out = model_vld | err_pulse;
    assign fifo_data_out  = err_pulse ? 32'hdeadbeef : model_data;

    fifo_drain #(
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
`ifdef FIFO_DRAIN_CKSUM_EN
        .cksum          (cksum),
        .cksum_clr      (cksum_clr),
`endif
        .fifo_empty     (fifo_empty),
        .fifo_r_en      (fifo_r_en),
        .fifo_valid_out (fifo_valid_out),
        .fifo_data_out  (fifo_data_out),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_eow       (byte_eow),
        .byte_ready     (byte_ready),
        .word_count     (word_count),
        .proto_err      (proto_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), w[8*i +: 8]});
    endtask

    // FIFO read port: read request sampled mid-cycle, data returned one cycle later.
    always @(negedge clock) model_rd = fifo_r_en;

    always @(posedge clock) begin
        #2;
        if (model_rd && reset_n && fifo_q.size() > 0) begin
            model_vld  = 1'b1;
            model_data = fifo_q.pop_front();
        end else begin
            model_vld  = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    // Scoreboard: every accepted byte is compared with the next expected one.
    always @(negedge clock) begin
        if (reset_n && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("sb_byte", 32'(byte_data), 32'(e[7:0]));
                check("sb_eow", 32'(byte_eow), 32'(e[8]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_rd;
        int reads;
        logic seen;
        logic seen_v;

        reset_n    = 1'b0;
        fifo_empty = 1'b1;
        model_rd   = 1'b0;
        model_vld  = 1'b0;
        model_data = '0;
        err_pulse  = 1'b0;
        byte_ready = 1'b1;
`ifdef FIFO_DRAIN_CKSUM_EN
        cksum_clr  = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_r_en", 32'(fifo_r_en), 0);
        check("rst_byte_valid", 32'(byte_valid), 0);
        check("rst_byte_data", 32'(byte_data), 0);
        check("rst_byte_eow", 32'(byte_eow), 0);
        check("rst_word_count", 32'(word_count), 0);
        check("rst_proto_err", 32'(proto_err), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Single word with latency check
        @(posedge clock); #1;
        push_word(32'h44332211);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (fifo_r_en) seen = 1'b1;
        end
        check("single_r_en_seen", 32'(seen), 1);
        @(negedge clock);
        check("lat_c1_valid", 32'(byte_valid), 0);
        @(negedge clock);
        check("lat_c2_valid", 32'(byte_valid), 1);
        check("lat_c2_data", 32'(byte_data), 32'h11);
        repeat (4) @(negedge clock);
        check("single_valid_done", 32'(byte_valid), 0);
        check("single_word_count", 32'(word_count), 1);

        // Back-pressure: three words queued while stalled
        @(posedge clock); #1;
        byte_ready = 1'b0;
        push_word(32'h44332211);
        push_word(32'h88776655);
        push_word(32'hccbbaa99);
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (fifo_r_en) reads++;
        end
        check("bp_reads", 32'(reads), (BUF_DEPTH + 1 < 3) ? BUF_DEPTH + 1 : 3);
        check("bp_hold_valid", 32'(byte_valid), 1);
        check("bp_hold_data", 32'(byte_data), 32'h11);
        check("bp_hold_eow", 32'(byte_eow), 0);
        @(posedge clock); #1;
        byte_ready = 1'b1;
        seen_v = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            seen_v = seen_v & byte_valid;
        end
        check("bp_no_bubble", 32'(seen_v), 1);
        @(negedge clock);
        check("bp_valid_done", 32'(byte_valid), 0);
        check("bp_word_count", 32'(word_count), 4);
        check("bp_sb_empty", 32'(exp_q.size()), 0);

        // Empty gating
        seen = 1'b0;
        seen_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            seen   = seen | fifo_r_en;
            seen_v = seen_v | byte_valid;
        end
        check("empty_r_en", 32'(seen), 0);
        check("empty_byte_valid", 32'(seen_v), 0);

        // Protocol error: valid with no read in flight
        @(posedge clock); #1;
        err_pulse = 1'b1;
        @(posedge clock); #1;
        err_pulse = 1'b0;
        @(negedge clock);
        check("perr_set", 32'(proto_err), 1);
        seen_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            seen_v = seen_v | byte_valid;
        end
        check("perr_no_output", 32'(seen_v), 0);
        check("perr_sticky", 32'(proto_err), 1);
        check("perr_word_count", 32'(word_count), 4);

        // Reset in the middle of a word
        @(posedge clock); #1;
        push_word(32'ha4a3a2a1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (byte_valid && byte_data == 8'ha3) seen = 1'b1;
        end
        check("midrst_reached", 32'(seen), 1);
        reset_n = 1'b0;
        #1;
        check("midrst_r_en", 32'(fifo_r_en), 0);
        check("midrst_byte_valid", 32'(byte_valid), 0);
        check("midrst_byte_data", 32'(byte_data), 0);
        check("midrst_byte_eow", 32'(byte_eow), 0);
        check("midrst_word_count", 32'(word_count), 0);
        check("midrst_proto_err", 32'(proto_err), 0);
`ifdef FIFO_DRAIN_CKSUM_EN
        check("midrst_cksum", 32'(cksum), 0);
`endif
        exp_q.delete();
        fifo_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Recovery after reset, checksum of one word
        @(posedge clock); #1;
        push_word(32'h44332211);
        repeat (10) @(negedge clock);
        check("post_rst_word_count", 32'(word_count), 1);
        check("post_rst_sb_empty", 32'(exp_q.size()), 0);
`ifdef FIFO_DRAIN_CKSUM_EN
        check("cksum_value", 32'(cksum), 32'h44);
        @(posedge clock); #1;
        cksum_clr = 1'b1;
        @(posedge clock); #1;
        cksum_clr = 1'b0;
        @(negedge clock);
        check("cksum_clear", 32'(cksum), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
